// File: rtl/i2c_cmd_seq_if.sv
// Host-side command/response handshake bundle for i2c_cmd_seq.
// master = host/register logic, slave = the sequencer.
interface i2c_cmd_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [6:0] cmd_dev;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_rw, cmd_dev, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_dev, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/i2c_cmd_seq.sv
// Command sequencer for i2c_ctrl: queues single-byte read/write commands,
// runs them one at a time on the controller and returns one response each.
module i2c_cmd_seq #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TW      = 11
) (
   input  logic         clk,
   input  logic         rst,
   i2c_cmd_seq_if.slave host,
   output logic         ctrl_rstn,
   output logic [7:0]   ctrl_addr,
   output logic [7:0]   ctrl_wdata,
   output logic         ctrl_data_oe,
   input  logic [7:0]   ctrl_rdata,
   input  logic         ctrl_busy,
   input  logic         ctrl_data_rdy
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          ne_q, ne_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          rw_q, rw_d;
   logic          ctrl_rstn_q, ctrl_rstn_d;
   logic [7:0]    ctrl_addr_q, ctrl_addr_d;
   logic [7:0]    ctrl_wdata_q, ctrl_wdata_d;
   logic          ctrl_data_oe_q, ctrl_data_oe_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic          full;
   logic          push;
   logic          pop;
   logic [15:0]   head;

   assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push = host.cmd_valid && !full;
   // FSM only looks at the registered occupancy flag, so a push reaches
   // IDLE one cycle later; a stale flag can only be stale-empty because
   // pops happen solely in IDLE and IDLE is never entered from IDLE's pop.
   assign pop  = (state_q == IDLE) && ne_q;
   assign head = mem_q[rd_ptr_q[AW-1:0]];

   assign host.cmd_ready = !full;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_rdata = rsp_rdata_q;
   assign host.rsp_err   = rsp_err_q;
   assign ctrl_rstn      = ctrl_rstn_q;
   assign ctrl_addr      = ctrl_addr_q;
   assign ctrl_wdata     = ctrl_wdata_q;
   assign ctrl_data_oe   = ctrl_data_oe_q;

   // Next-state logic for the FIFO and the transaction sequencer.
   always_comb begin
      state_d        = state_q;
      mem_d          = mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      ne_d           = (wr_ptr_q != rd_ptr_q);
      cnt_d          = cnt_q;
      rw_d           = rw_q;
      ctrl_rstn_d    = ctrl_rstn_q;
      ctrl_addr_d    = ctrl_addr_q;
      ctrl_wdata_d   = ctrl_wdata_q;
      ctrl_data_oe_d = ctrl_data_oe_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_err_d      = rsp_err_q;

      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {host.cmd_rw, host.cmd_dev, host.cmd_wdata};
         wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end

      case (state_q)
         IDLE: begin
            if (ne_q) begin
               rw_d         = head[15];
               ctrl_addr_d  = {head[14:8], head[15]};
               ctrl_wdata_d = head[7:0];
               state_d      = LAUNCH;
            end
         end
         LAUNCH: begin
            ctrl_rstn_d    = 1'b1;
            ctrl_data_oe_d = !rw_q;
            cnt_d          = '0;
            rsp_rdata_d    = '0;
            rsp_err_d      = 1'b0;
            state_d        = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
            if (rw_q && !ctrl_data_rdy) begin
               rsp_rdata_d = ctrl_rdata;
            end
            // cnt_q != 0 means busy is sampled no earlier than 2 cycles
            // after launch; normal completion is tested first so it wins.
            if (!ctrl_busy && (cnt_q != '0)) begin
               ctrl_rstn_d    = 1'b0;
               ctrl_data_oe_d = 1'b0;
               rsp_valid_d    = 1'b1;
               rsp_err_d      = 1'b0;
               state_d        = RESP;
            end else if (ctrl_busy && (cnt_q == TW'(TIMEOUT - 1))) begin
               ctrl_rstn_d    = 1'b0;
               ctrl_data_oe_d = 1'b0;
               rsp_valid_d    = 1'b1;
               rsp_err_d      = 1'b1;
               rsp_rdata_d    = '0;
               state_d        = RESP;
            end
         end
         RESP: begin
            if (host.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset empties the FIFO and abandons any transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         ne_q           <= 1'b0;
         cnt_q          <= '0;
         rw_q           <= 1'b0;
         ctrl_rstn_q    <= 1'b0;
         ctrl_addr_q    <= '0;
         ctrl_wdata_q   <= '0;
         ctrl_data_oe_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_q          <= mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         ne_q           <= ne_d;
         cnt_q          <= cnt_d;
         rw_q           <= rw_d;
         ctrl_rstn_q    <= ctrl_rstn_d;
         ctrl_addr_q    <= ctrl_addr_d;
         ctrl_wdata_q   <= ctrl_wdata_d;
         ctrl_data_oe_q <= ctrl_data_oe_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_err_q      <= rsp_err_d;
      end
   end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq with a behavioural i2c_ctrl stand-in.
module tb_i2c_cmd_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ctrl_rstn;
   logic [7:0] ctrl_addr;
   logic [7:0] ctrl_wdata;
   logic       ctrl_data_oe;
   logic [7:0] ctrl_rdata    = 8'h00;
   logic       ctrl_busy     = 1'b0;
   logic       ctrl_data_rdy = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   // controller model knobs
   bit         stuck      = 1'b0;
   int         busy_len   = 20;
   logic [7:0] rd_default = 8'h00;
   logic [7:0] rd_fifo[$];
   logic [7:0] cur_rd     = 8'h00;
   int         mcnt       = 0;
   int         launches   = 0;

   i2c_cmd_seq_if bus ();

   i2c_cmd_seq #(.DEPTH(4), .TIMEOUT(1024), .TW(11)) dut (
      .clk(clk), .rst(rst), .host(bus),
      .ctrl_rstn(ctrl_rstn), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
      .ctrl_data_oe(ctrl_data_oe), .ctrl_rdata(ctrl_rdata),
      .ctrl_busy(ctrl_busy), .ctrl_data_rdy(ctrl_data_rdy)
   );

   always #5 clk = ~clk;

   // i2c_ctrl stand-in: busy for busy_len cycles after rstn rises, read
   // byte valid (data_rdy low) on the last two busy cycles.
   always @(negedge clk) begin
      if (ctrl_rstn !== 1'b1) begin
         mcnt = 0; ctrl_busy = 1'b0; ctrl_data_rdy = 1'b1; ctrl_rdata = 8'h00;
      end else begin
         if (mcnt == 0) begin
            launches++;
            cur_rd = (rd_fifo.size() > 0) ? rd_fifo.pop_front() : rd_default;
         end
         mcnt++;
         if (stuck) begin
            ctrl_busy = 1'b1; ctrl_data_rdy = 1'b0; ctrl_rdata = 8'h77;
         end else begin
            ctrl_busy = (mcnt <= busy_len);
            if (mcnt >= busy_len - 1 && mcnt <= busy_len) begin
               ctrl_data_rdy = 1'b0; ctrl_rdata = cur_rd;
            end else begin
               ctrl_data_rdy = 1'b1; ctrl_rdata = 8'hEE;
            end
         end
      end
   end

   task automatic push(input logic rw, input logic [6:0] dev, input logic [7:0] wd, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_dev = dev; bus.cmd_wdata = wd;
      for (int i = 0; i < 3000; i++) begin
         if (bus.cmd_ready) begin @(posedge clk); ok = 1'b1; break; end
         @(negedge clk);
      end
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rstn(output bit ok, output int n);
      ok = 1'b0; n = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1; n++;
         if (ctrl_rstn === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(output bit ok, output int n);
      ok = 1'b0; n = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1; n++;
         if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic ack_rsp();
      @(negedge clk); bus.rsp_ready = 1'b1;
      @(posedge clk); #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
      n_checks++; if (ctrl_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_rstn: got %b want 0", ctrl_rstn); end
      n_checks++; if (ctrl_addr !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_addr: got %h want 00", ctrl_addr); end
      n_checks++; if (ctrl_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_wdata: got %h want 00", ctrl_wdata); end
      n_checks++; if (ctrl_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_oe: got %b want 0", ctrl_data_oe); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_write();
      bit ok; int n;
      stuck = 1'b0; busy_len = 20; rd_default = 8'h5A;
      push(1'b0, 7'h50, 8'hA5, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_push: got not-accepted want accepted"); end
      wait_rstn(ok, n);
      n_checks++; if (!ok || n != 3) begin n_fail++; $display("FAIL wr_launch_latency: got %0d want 3", n); end
      n_checks++; if (ctrl_addr !== 8'hA0) begin n_fail++; $display("FAIL wr_ctrl_addr: got %h want a0", ctrl_addr); end
      n_checks++; if (ctrl_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_ctrl_wdata: got %h want a5", ctrl_wdata); end
      n_checks++; if (ctrl_data_oe !== 1'b1) begin n_fail++; $display("FAIL wr_ctrl_oe: got %b want 1", ctrl_data_oe); end
      wait_rsp(ok, n);
      n_checks++; if (!ok || n != 21) begin n_fail++; $display("FAIL wr_rsp_latency: got %0d want 21", n); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %b want 0", bus.rsp_err); end
      n_checks++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h want 00", bus.rsp_rdata); end
      n_checks++; if (ctrl_rstn !== 1'b0 || ctrl_data_oe !== 1'b0) begin n_fail++; $display("FAIL wr_resp_ctrl_idle: got rstn=%b oe=%b want 0 0", ctrl_rstn, ctrl_data_oe); end
      n_checks++; if (ctrl_addr !== 8'hA0) begin n_fail++; $display("FAIL wr_resp_addr_hold: got %h want a0", ctrl_addr); end
      ack_rsp();
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_drop: got %b want 0", bus.rsp_valid); end
   endtask

   task automatic test_read();
      bit ok; int n;
      stuck = 1'b0; busy_len = 10; rd_fifo.push_back(8'h3C);
      push(1'b1, 7'h68, 8'h00, ok);
      wait_rstn(ok, n);
      n_checks++; if (!ok || n != 3) begin n_fail++; $display("FAIL rd_launch_latency: got %0d want 3", n); end
      n_checks++; if (ctrl_addr !== 8'hD1) begin n_fail++; $display("FAIL rd_ctrl_addr: got %h want d1", ctrl_addr); end
      n_checks++; if (ctrl_data_oe !== 1'b0) begin n_fail++; $display("FAIL rd_ctrl_oe: got %b want 0", ctrl_data_oe); end
      wait_rsp(ok, n);
      n_checks++; if (!ok || n != 11) begin n_fail++; $display("FAIL rd_rsp_latency: got %0d want 11", n); end
      n_checks++; if (bus.rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 3c", bus.rsp_rdata); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_err: got %b want 0", bus.rsp_err); end
      ack_rsp();
   endtask

   task automatic test_timeout();
      bit ok; int n;
      stuck = 1'b1;
      push(1'b1, 7'h33, 8'h00, ok);
      push(1'b0, 7'h44, 8'h99, ok);
      wait_rstn(ok, n);
      n_checks++; if (ctrl_addr !== 8'h67) begin n_fail++; $display("FAIL to_ctrl_addr: got %h want 67", ctrl_addr); end
      wait_rsp(ok, n);
      n_checks++; if (!ok || n != 1024) begin n_fail++; $display("FAIL to_latency: got %0d want 1024", n); end
      n_checks++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp_err: got %b want 1", bus.rsp_err); end
      n_checks++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL to_rsp_rdata: got %h want 00", bus.rsp_rdata); end
      n_checks++; if (ctrl_rstn !== 1'b0) begin n_fail++; $display("FAIL to_resp_rstn: got %b want 0", ctrl_rstn); end
      stuck = 1'b0; busy_len = 4;
      ack_rsp();
      wait_rstn(ok, n);
      n_checks++; if (!ok || n != 2) begin n_fail++; $display("FAIL to_next_launch: got %0d want 2", n); end
      n_checks++; if (ctrl_addr !== 8'h88 || ctrl_wdata !== 8'h99) begin n_fail++; $display("FAIL to_next_cmd: got %h/%h want 88/99", ctrl_addr, ctrl_wdata); end
      wait_rsp(ok, n);
      n_checks++; if (!ok || n != 5 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_next_rsp: got n=%0d err=%b want 5 0", n, bus.rsp_err); end
      ack_rsp();
   endtask

   task automatic test_fifo_full();
      bit ok; int n; int acc; int seen;
      logic [7:0] exp_addr;
      stuck = 1'b1; acc = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bus.cmd_valid = (acc < 6); bus.cmd_rw = 1'b0;
         bus.cmd_dev = 7'h10 + 7'(acc); bus.cmd_wdata = 8'(acc);
         if (bus.cmd_valid && bus.cmd_ready) acc++;
      end
      @(posedge clk); #1 bus.cmd_valid = 1'b0;
      n_checks++; if (acc != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", acc); end
      n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_cmd_ready: got %b want 0", bus.cmd_ready); end
      wait_rsp(ok, n);
      n_checks++; if (!ok || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL full_first_rsp: got ok=%b err=%b want 1 1", ok, bus.rsp_err); end
      stuck = 1'b0; busy_len = 3;
      ack_rsp();
      @(posedge clk); #1;
      n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again: got %b want 1", bus.cmd_ready); end
      for (int i = 1; i < 5; i++) begin
         exp_addr = {7'(16 + i), 1'b0};
         wait_rsp(ok, n);
         n_checks++; if (!ok || ctrl_addr !== exp_addr || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL full_drain_%0d: got addr=%h err=%b want %h 0", i, ctrl_addr, bus.rsp_err, exp_addr); end
         ack_rsp();
      end
      seen = 0;
      repeat (20) begin @(posedge clk); #1; if (ctrl_rstn !== 1'b0 || bus.rsp_valid !== 1'b0) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL full_sixth_dropped: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_back_to_back();
      bit ok; int n; int lc; bit stable;
      logic [7:0] r;
      logic [7:0] exp_rd [3];
      exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
      stuck = 1'b0; busy_len = 6;
      for (int i = 0; i < 3; i++) rd_fifo.push_back(exp_rd[i]);
      for (int i = 0; i < 3; i++) push(1'b1, 7'h20 + 7'(i), 8'h00, ok);
      for (int i = 0; i < 3; i++) begin
         wait_rsp(ok, n);
         lc = launches; r = bus.rsp_rdata; stable = 1'b1;
         repeat (10) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r || bus.rsp_err !== 1'b0 || ctrl_rstn !== 1'b0) stable = 1'b0;
         end
         n_checks++; if (!ok || r !== exp_rd[i]) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h want %h", i, r, exp_rd[i]); end
         n_checks++; if (!stable) begin n_fail++; $display("FAIL b2b_stall_stable_%0d: got unstable want stable", i); end
         n_checks++; if (launches != lc) begin n_fail++; $display("FAIL b2b_no_launch_%0d: got %0d want %0d", i, launches, lc); end
         ack_rsp();
         if (i < 2) begin
            wait_rstn(ok, n);
            n_checks++; if (!ok || n != 2) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d want 2", i, n); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int n; int lc; int seen;
      stuck = 1'b0; busy_len = 50;
      for (int i = 0; i < 3; i++) push(1'b0, 7'h40 + 7'(i), 8'(i), ok);
      wait_rstn(ok, n);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (ctrl_rstn !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl_rstn: got %b want 0", ctrl_rstn); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 0", bus.rsp_valid); end
      n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cmd_ready: got %b want 1", bus.cmd_ready); end
      rst = 1'b0; lc = launches; seen = 0;
      repeat (40) begin @(posedge clk); #1; if (ctrl_rstn !== 1'b0 || bus.rsp_valid !== 1'b0) seen++; end
      n_checks++; if (seen != 0 || launches != lc) begin n_fail++; $display("FAIL rmid_fifo_empty: got %0d active cycles %0d launches want 0 0", seen, launches - lc); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_dev = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_fifo_full();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
